// File: rtl/adc_align_pkg.sv
// Shared definitions for the ADC lane word-alignment controller:
// FSM state encodings and the counter-width helper.
package adc_align_pkg;

    localparam logic [2:0] STATE_IDLE       = 3'd0;
    localparam logic [2:0] STATE_RST_SERDES = 3'd1;
    localparam logic [2:0] STATE_SETTLE     = 3'd2;
    localparam logic [2:0] STATE_CHECK      = 3'd3;
    localparam logic [2:0] STATE_SLIP       = 3'd4;
    localparam logic [2:0] STATE_LOCKED     = 3'd5;
    localparam logic [2:0] STATE_FAIL       = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE       = STATE_IDLE,
        ST_RST_SERDES = STATE_RST_SERDES,
        ST_SETTLE     = STATE_SETTLE,
        ST_CHECK      = STATE_CHECK,
        ST_SLIP       = STATE_SLIP,
        ST_LOCKED     = STATE_LOCKED,
        ST_FAIL       = STATE_FAIL
    } align_state_e;

    // Width of a counter that must be able to hold 'value' (never below 1 bit).
    function automatic int clog2_sat(input int value);
        if (value < 1) begin
            return 1;
        end else begin
            return $clog2(value + 1);
        end
    endfunction

endpackage

// File: rtl/adc_word_shifter.sv
// Fabric barrel shifter for the ADC lane: keeps the previous deserialized
// word, selects an SR-bit window out of {q_prev, q_in} at slip_offset and
// registers the result as data_out. Offset 0 selects q_prev unchanged.
module adc_word_shifter
    import adc_align_pkg::*;
#(
    parameter int SR = 8,
    localparam int CW = $clog2(SR)
) (
    input  logic          clk_div,
    input  logic          rst_n,
    input  logic [SR-1:0] q_in,
    input  logic          q_valid,
    input  logic [CW-1:0] slip_offset,
    input  logic          locked,
    output logic [SR-1:0] aligned,
    output logic [SR-1:0] data_out,
    output logic          data_valid
);

    logic [SR-1:0]   q_prev_q;
    logic [SR-1:0]   q_prev_d;
    logic [SR-1:0]   data_out_q;
    logic [SR-1:0]   data_out_d;
    logic            data_valid_q;
    logic            data_valid_d;
    logic [2*SR-1:0] win_s;
    logic [2*SR-1:0] shifted_s;

    // Window select: shifting left by the offset moves the wanted slice to the top half.
    always_comb begin
        win_s     = {q_prev_q, q_in};
        shifted_s = win_s << slip_offset;
        aligned   = shifted_s[2*SR-1 -: SR];
    end

    // Next-state for the datapath: everything advances only on valid words.
    always_comb begin
        q_prev_d     = q_prev_q;
        data_out_d   = data_out_q;
        data_valid_d = q_valid & locked;
        if (q_valid) begin
            q_prev_d   = q_in;
            data_out_d = aligned;
        end else begin
            q_prev_d   = q_prev_q;
            data_out_d = data_out_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            q_prev_q     <= {SR{1'b0}};
            data_out_q   <= {SR{1'b0}};
            data_valid_q <= 1'b0;
        end else begin
            q_prev_q     <= q_prev_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;

endmodule

// File: rtl/adc_lane_align_ctrl.sv
// Word-alignment controller for one ADC LVDS lane behind a 1:SERDES_RATIO
// deserializer without bitslip. Resets the deserializer, lets it settle,
// then sweeps the fabric shift offset until the training pattern is seen on
// MATCH_COUNT consecutive valid words.
// Optional build macro ADC_ALIGN_MONITOR_EN: adds a train_mode input and a
// post-lock monitor that drops lock and realigns after MISMATCH_LIMIT
// consecutive bad training words.
module adc_lane_align_ctrl
    import adc_align_pkg::*;
#(
    parameter int SERDES_RATIO   = 8,
    parameter int MATCH_COUNT    = 16,
    parameter int RST_CYCLES     = 8,
    parameter int SETTLE_CYCLES  = 32,
    parameter int MAX_SWEEPS     = 2,
    parameter int MISMATCH_LIMIT = 4,
    localparam int CW = $clog2(SERDES_RATIO)
) (
    input  logic                    clk_div,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [SERDES_RATIO-1:0] train_pattern,
    input  logic [SERDES_RATIO-1:0] q_in,
    input  logic                    q_valid,
`ifdef ADC_ALIGN_MONITOR_EN
    input  logic                    train_mode,
`endif
    output logic                    serdes_rst,
    output logic [SERDES_RATIO-1:0] data_out,
    output logic                    data_valid,
    output logic [CW-1:0]           slip_offset,
    output logic                    busy,
    output logic                    locked,
    output logic                    align_fail
);

    localparam int TMR_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = clog2_sat(TMR_MAX);
    localparam int MATCH_W = clog2_sat(MATCH_COUNT);
    localparam int SWP_W   = clog2_sat(MAX_SWEEPS);
    localparam int MIS_W   = clog2_sat(MISMATCH_LIMIT);

    localparam logic [TMR_W-1:0]   RST_LAST    = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0]   SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST  = MATCH_W'(MATCH_COUNT - 1);
    localparam logic [SWP_W-1:0]   SWEEP_LAST  = SWP_W'(MAX_SWEEPS - 1);
    localparam logic [MIS_W-1:0]   MIS_LAST    = MIS_W'(MISMATCH_LIMIT - 1);
    localparam logic [CW-1:0]      OFF_LAST    = CW'(SERDES_RATIO - 1);

    align_state_e              state_q, state_d;
    logic [CW-1:0]             offset_q, offset_d;
    logic [SWP_W-1:0]          sweep_cnt_q, sweep_cnt_d;
    logic [TMR_W-1:0]          tmr_q, tmr_d;
    logic [MATCH_W-1:0]        match_cnt_q, match_cnt_d;
    logic [MIS_W-1:0]          mis_cnt_q, mis_cnt_d;
    logic                      serdes_rst_q, serdes_rst_d;
    logic                      busy_q, busy_d;
    logic                      locked_q, locked_d;
    logic                      align_fail_q, align_fail_d;
    logic                      enter_rst_s;
    logic                      train_mode_s;
    logic                      word_ok_s;
    logic [SERDES_RATIO-1:0]   aligned_s;

`ifdef ADC_ALIGN_MONITOR_EN
    assign train_mode_s = train_mode;
`else
    // Without the monitor the lock is sticky: the monitor path never sees training mode.
    assign train_mode_s = 1'b0;
`endif

    assign word_ok_s = (aligned_s == train_pattern);

    adc_word_shifter #(
        .SR (SERDES_RATIO)
    ) u_shifter (
        .clk_div     (clk_div),
        .rst_n       (rst_n),
        .q_in        (q_in),
        .q_valid     (q_valid),
        .slip_offset (offset_q),
        .locked      (locked_q),
        .aligned     (aligned_s),
        .data_out    (data_out),
        .data_valid  (data_valid)
    );

    // Next-state, counter and registered-output logic of the alignment FSM.
    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        sweep_cnt_d = sweep_cnt_q;
        tmr_d       = tmr_q;
        match_cnt_d = match_cnt_q;
        mis_cnt_d   = mis_cnt_q;
        enter_rst_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    enter_rst_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RST_SERDES: begin
                if (tmr_q == RST_LAST) begin
                    state_d = ST_SETTLE;
                    tmr_d   = {TMR_W{1'b0}};
                end else begin
                    tmr_d   = tmr_q + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (tmr_q == SETTLE_LAST) begin
                    state_d     = ST_CHECK;
                    tmr_d       = {TMR_W{1'b0}};
                    match_cnt_d = {MATCH_W{1'b0}};
                end else begin
                    tmr_d       = tmr_q + 1'b1;
                end
            end
            ST_CHECK: begin
                // Idle cycles (q_valid=0) leave the match run untouched.
                if (q_valid) begin
                    if (word_ok_s) begin
                        if (match_cnt_q == MATCH_LAST) begin
                            state_d   = ST_LOCKED;
                            mis_cnt_d = {MIS_W{1'b0}};
                        end else begin
                            match_cnt_d = match_cnt_q + 1'b1;
                        end
                    end else begin
                        state_d = ST_SLIP;
                    end
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_SLIP: begin
                offset_d = offset_q + 1'b1;
                tmr_d    = {TMR_W{1'b0}};
                if (offset_q == OFF_LAST) begin
                    // Wrapping back to offset 0 completes one full sweep.
                    if (sweep_cnt_q == SWEEP_LAST) begin
                        state_d     = ST_FAIL;
                        offset_d    = {CW{1'b0}};
                        sweep_cnt_d = sweep_cnt_q + 1'b1;
                    end else begin
                        state_d     = ST_SETTLE;
                        sweep_cnt_d = sweep_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_LOCKED: begin
                if (start) begin
                    enter_rst_s = 1'b1;
                end else if (q_valid && train_mode_s) begin
                    if (word_ok_s) begin
                        mis_cnt_d = {MIS_W{1'b0}};
                    end else if (mis_cnt_q == MIS_LAST) begin
                        enter_rst_s = 1'b1;
                    end else begin
                        mis_cnt_d = mis_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            ST_FAIL: begin
                offset_d = {CW{1'b0}};
                if (start) begin
                    enter_rst_s = 1'b1;
                end else begin
                    state_d = ST_FAIL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every (re)alignment starts from a clean offset and sweep history.
        if (enter_rst_s) begin
            state_d     = ST_RST_SERDES;
            offset_d    = {CW{1'b0}};
            sweep_cnt_d = {SWP_W{1'b0}};
            tmr_d       = {TMR_W{1'b0}};
            match_cnt_d = {MATCH_W{1'b0}};
            mis_cnt_d   = {MIS_W{1'b0}};
        end else begin
            state_d = state_d;
        end

        // Outputs are registered copies of the next state so they change with the state.
        serdes_rst_d = (state_d == ST_RST_SERDES);
        busy_d       = (state_d == ST_RST_SERDES) || (state_d == ST_SETTLE) ||
                       (state_d == ST_CHECK)      || (state_d == ST_SLIP);
        locked_d     = (state_d == ST_LOCKED);
        align_fail_d = (state_d == ST_FAIL);
    end

    // FSM state, counters and output registers; reset drops serdes_rst at once.
    always_ff @(posedge clk_div or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            offset_q     <= {CW{1'b0}};
            sweep_cnt_q  <= {SWP_W{1'b0}};
            tmr_q        <= {TMR_W{1'b0}};
            match_cnt_q  <= {MATCH_W{1'b0}};
            mis_cnt_q    <= {MIS_W{1'b0}};
            serdes_rst_q <= 1'b0;
            busy_q       <= 1'b0;
            locked_q     <= 1'b0;
            align_fail_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            offset_q     <= offset_d;
            sweep_cnt_q  <= sweep_cnt_d;
            tmr_q        <= tmr_d;
            match_cnt_q  <= match_cnt_d;
            mis_cnt_q    <= mis_cnt_d;
            serdes_rst_q <= serdes_rst_d;
            busy_q       <= busy_d;
            locked_q     <= locked_d;
            align_fail_q <= align_fail_d;
        end
    end

    assign serdes_rst  = serdes_rst_q;
    assign slip_offset = offset_q;
    assign busy        = busy_q;
    assign locked      = locked_q;
    assign align_fail  = align_fail_q;

endmodule

// File: tb/tb_adc_lane_align_ctrl.sv
// Directed self-checking bench for adc_lane_align_ctrl (default parameters).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_adc_lane_align_ctrl;

    logic       clk_div;
    logic       rst_n;
    logic       start;
    logic [7:0] train_pattern;
    logic [7:0] q_in;
    logic       q_valid;
`ifdef ADC_ALIGN_MONITOR_EN
    logic       train_mode;
`endif
    logic       serdes_rst;
    logic [7:0] data_out;
    logic       data_valid;
    logic [2:0] slip_offset;
    logic       busy;
    logic       locked;
    logic       align_fail;

    int n_cmp = 0;
    int n_mis = 0;

    adc_lane_align_ctrl dut (
        .clk_div       (clk_div),
        .rst_n         (rst_n),
        .start         (start),
        .train_pattern (train_pattern),
        .q_in          (q_in),
        .q_valid       (q_valid),
`ifdef ADC_ALIGN_MONITOR_EN
        .train_mode    (train_mode),
`endif
        .serdes_rst    (serdes_rst),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .slip_offset   (slip_offset),
        .busy          (busy),
        .locked        (locked),
        .align_fail    (align_fail)
    );

    initial clk_div = 1'b0;
    always #5 clk_div = ~clk_div;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_div);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_locked(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (locked === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; q_valid = 1'b1; q_in = 8'hA5; train_pattern = 8'hA5;
`ifdef ADC_ALIGN_MONITOR_EN
        train_mode = 1'b0;
`endif
        #2;
        n_cmp++;
        if ({serdes_rst, data_valid, busy, locked, align_fail} !== 5'b00000) begin
            n_mis++;
            $display("FAIL reset_flags: got %b expected 00000", {serdes_rst, data_valid, busy, locked, align_fail});
        end
        n_cmp++;
        if (data_out !== 8'h00) begin
            n_mis++; $display("FAIL reset_data_out: got %h expected 00", data_out);
        end
        n_cmp++;
        if (slip_offset !== 3'd0) begin
            n_mis++; $display("FAIL reset_offset: got %0d expected 0", slip_offset);
        end
        tick(); rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        // No start: the controller stays idle.
        n_cmp++;
        if ({serdes_rst, busy, locked, data_valid} !== 4'b0000) begin
            n_mis++;
            $display("FAIL idle_no_start: got %b expected 0000", {serdes_rst, busy, locked, data_valid});
        end
    endtask

    // 8'h1E seen with a 3-bit lag arrives as rotr(1E,3) = C3; offsets 0..2 give C3, 87, 0F.
    task automatic test_lag3_lock();
        bit ok;
        apply_reset();
        train_pattern = 8'h1E; q_in = 8'hC3; q_valid = 1'b1;
        pulse_start();
        wait_locked(3000, ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_mis++; $display("FAIL t1_lock: locked never rose within 3000 cycles, expected lock");
        end
        n_cmp++;
        if (slip_offset !== 3'd3) begin
            n_mis++; $display("FAIL t1_offset: got %0d expected 3", slip_offset);
        end
        n_cmp++;
        if (align_fail !== 1'b0) begin
            n_mis++; $display("FAIL t1_align_fail: got %b expected 0", align_fail);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++;
            if ({data_valid, data_out} !== {1'b1, 8'h1E}) begin
                n_mis++;
                $display("FAIL t1_data[%0d]: got valid=%b data=%h expected valid=1 data=1e", i, data_valid, data_out);
            end
        end
        // Restart from LOCKED: lock drops together with entry into the reset phase.
        pulse_start();
        n_cmp++;
        if ({locked, busy, serdes_rst} !== 3'b011) begin
            n_mis++;
            $display("FAIL t1_restart: got locked,busy,serdes_rst=%b expected 011", {locked, busy, serdes_rst});
        end
    endtask

    // Aligned stream: start sampled at edge 0, serdes_rst for 8 edges, settle 32,
    // 16 matches -> lock visible after edge 56 (58th cycle counting the start cycle).
    task automatic test_aligned_timing();
        int  n;
        int  sr_cnt;
        bit  got;
        apply_reset();
        train_pattern = 8'h3C; q_in = 8'h3C; q_valid = 1'b1;
        pulse_start();
        n = -1; sr_cnt = 0; got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (serdes_rst === 1'b1) sr_cnt++;
            if (locked === 1'b1) begin
                n = i; got = 1'b1;
                break;
            end
            // A start pulse while busy (in SETTLE) must not disturb the sequence.
            start = (i == 20) ? 1'b1 : 1'b0;
            tick();
        end
        start = 1'b0;
        n_cmp++;
        if (got !== 1'b1) begin
            n_mis++; $display("FAIL t2_lock: no lock within 200 cycles, expected lock");
        end
        n_cmp++;
        if (n !== 56) begin
            n_mis++; $display("FAIL t2_lock_time: got %0d edges expected 56", n);
        end
        n_cmp++;
        if (sr_cnt !== 8) begin
            n_mis++; $display("FAIL t2_serdes_rst_len: got %0d cycles expected 8", sr_cnt);
        end
        n_cmp++;
        if (slip_offset !== 3'd0) begin
            n_mis++; $display("FAIL t2_offset: got %0d expected 0", slip_offset);
        end
    endtask

    // Pattern 00 with every word's LSB set: each window contains q_prev[0]=1, never a match.
    task automatic test_sweep_fail();
        int       changes;
        logic [2:0] prev;
        apply_reset();
        train_pattern = 8'h00; q_valid = 1'b1; q_in = 8'h01;
        pulse_start();
        changes = 0;
        for (int i = 0; i < 3000; i++) begin
            if (align_fail === 1'b1) break;
            q_in = 8'($urandom) | 8'h01;
            prev = slip_offset;
            tick();
            if (slip_offset !== prev) changes++;
        end
        n_cmp++;
        if (align_fail !== 1'b1) begin
            n_mis++; $display("FAIL t3_align_fail: got %b expected 1", align_fail);
        end
        n_cmp++;
        if (changes !== 16) begin
            n_mis++; $display("FAIL t3_slips: got %0d offset changes expected 16", changes);
        end
        n_cmp++;
        if ({locked, busy} !== 2'b00) begin
            n_mis++; $display("FAIL t3_flags: got locked,busy=%b expected 00", {locked, busy});
        end
        n_cmp++;
        if (slip_offset !== 3'd0) begin
            n_mis++; $display("FAIL t3_offset: got %0d expected 0", slip_offset);
        end
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if (align_fail !== 1'b1) begin
            n_mis++; $display("FAIL t3_sticky: got %b expected 1", align_fail);
        end
        pulse_start();
        n_cmp++;
        if ({align_fail, busy} !== 2'b01) begin
            n_mis++; $display("FAIL t3_restart: got align_fail,busy=%b expected 01", {align_fail, busy});
        end
    endtask

    // q_valid high on even cycles k (start cycle k=0); CHECK starts after edge 40,
    // valid matches on edges 42,44,...,72 -> lock after edge 72.
    task automatic test_valid_gaps();
        int  k_lock;
        logic qv;
        apply_reset();
        train_pattern = 8'h5A; q_in = 8'h5A; q_valid = 1'b1;
        pulse_start();
        k_lock = -1;
        for (int k = 1; k < 200; k++) begin
            q_valid = (k % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            if (locked === 1'b1) begin
                k_lock = k;
                break;
            end
        end
        n_cmp++;
        if (k_lock !== 72) begin
            n_mis++; $display("FAIL t4_lock_edge: got %0d expected 72", k_lock);
        end
        for (int j = 0; j < 8; j++) begin
            qv = (j % 2 == 0) ? 1'b1 : 1'b0;
            q_valid = qv;
            tick();
            n_cmp++;
            if (data_valid !== qv) begin
                n_mis++; $display("FAIL t4_data_valid[%0d]: got %b expected %b", j, data_valid, qv);
            end
        end
    endtask

    // 1E lagged so that offset 6 aligns (q_in = 78); stall CHECK at offset 5 with q_valid=0.
    task automatic test_reset_mid_check();
        bit ok;
        apply_reset();
        train_pattern = 8'h1E; q_in = 8'h78; q_valid = 1'b1;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (slip_offset === 3'd5) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_cmp++;
        if (ok !== 1'b1) begin
            n_mis++; $display("FAIL t5_reach_off5: offset 5 never reached, got %0d", slip_offset);
        end
        q_valid = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        n_cmp++;
        if ({busy, slip_offset} !== {1'b1, 3'd5}) begin
            n_mis++; $display("FAIL t5_stalled: got busy=%b off=%0d expected busy=1 off=5", busy, slip_offset);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({serdes_rst, busy, locked, align_fail, data_valid, slip_offset} !== 8'h00) begin
            n_mis++;
            $display("FAIL t5_async_reset: got rst=%b busy=%b lock=%b fail=%b dv=%b off=%0d expected all 0",
                     serdes_rst, busy, locked, align_fail, data_valid, slip_offset);
        end
        tick();
        rst_n = 1'b1; q_valid = 1'b1;
        tick();
        pulse_start();
        wait_locked(3000, ok);
        n_cmp++;
        if ({ok, slip_offset} !== {1'b1, 3'd6}) begin
            n_mis++; $display("FAIL t5_relock: got lock=%b off=%0d expected lock=1 off=6", ok, slip_offset);
        end
        tick();
        n_cmp++;
        if (data_out !== 8'h1E) begin
            n_mis++; $display("FAIL t5_data: got %h expected 1e", data_out);
        end
    endtask

`ifdef ADC_ALIGN_MONITOR_EN
    // Offset 0: aligned = q_prev, so a bad q_in word shows up one edge later.
    task automatic test_monitor();
        bit ok;
        apply_reset();
        train_pattern = 8'h3C; q_in = 8'h3C; q_valid = 1'b1; train_mode = 1'b1;
        pulse_start();
        wait_locked(500, ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_mis++; $display("FAIL t6_lock: got %b expected 1", ok);
        end
        q_in = 8'h00;
        for (int i = 0; i < 3; i++) tick();
        q_in = 8'h3C;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++;
        if (locked !== 1'b1) begin
            n_mis++; $display("FAIL t6_three_bad: got locked=%b expected 1", locked);
        end
        q_in = 8'h00;
        for (int i = 0; i < 6; i++) tick();
        n_cmp++;
        if ({locked, serdes_rst} !== 2'b01) begin
            n_mis++; $display("FAIL t6_four_bad: got locked,serdes_rst=%b expected 01", {locked, serdes_rst});
        end
        train_mode = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_lag3_lock();
        test_aligned_timing();
        test_sweep_fail();
        test_valid_gaps();
        test_reset_mid_check();
`ifdef ADC_ALIGN_MONITOR_EN
        test_monitor();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
